vga_2bit_rx: RTL and testbench

Receive-side monitor for the 2-bit-per-colour VGA stream (Hs, Vs, Blank, R/G/B[1:0]) that the VGA generator drives. It sits on the same pixel clock and recovers the timing: line length, active width, frame height and active height. It also computes a per-frame pixel checksum and reports timing lock. It is used in loop-back self-test and as a bench scoreboard for the generator.

---
 rtl/vga_2bit_pkg.sv | 31 +++
 rtl/vga_sync_edge.sv | 26 ++
 rtl/vga_2bit_rx.sv | 251 +++++++++++++++++++++++++
 tb/tb_vga_2bit_rx.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_2bit_pkg.sv
// Shared types and helpers for the 2-bit VGA receive monitor.
// Holds the lock FSM state enum, CRC-16-CCITT constants and a 6-bit CRC step.
package vga_2bit_pkg;

   typedef enum logic [1:0] {
      SEARCH,
      FIRST,
      CHECK,
      LOCKED
   } rx_state_t;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;

   // Advance the CRC over one 6-bit pixel, MSB first.
   function automatic logic [15:0] crc16_step6(
      input logic [15:0] crc,
      input logic [5:0]  pixel
   );
      logic [15:0] c;
      c = crc;
      for (int i = 5; i >= 0; i--) begin
         if (c[15] ^ pixel[i])
            c = {c[14:0], 1'b0} ^ CRC_POLY;
         else
            c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input history register and start-of-pulse detector.
// Ports: clk, reset (sync, active-high), sync (raw input), start (pulse in
// the cycle the active level first appears on sync). ACTIVE_LOW picks polarity.
module vga_sync_edge #(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sync,
   output logic start
);

   localparam logic IDLE = ACTIVE_LOW;

   logic sync_d;

   always_ff @(posedge clk) begin
      if (reset)
         sync_d <= IDLE;
      else
         sync_d <= sync;
   end

   assign start = (sync != IDLE) && (sync_d == IDLE);

endmodule

// File: rtl/vga_2bit_rx.sv
// Receive-side timing monitor for the 2-bit-per-colour VGA stream.
// Ports: clk, reset (sync, active-high), hs/vs/blank/r/g/b stream inputs;
// h_total, h_active, v_total, v_active, frame_sum measured per frame,
// frame_valid (publish pulse), locked, timing_err (mismatch/overflow pulse).
// Build option VGA_RX_CRC_EN: frame_sum carries a CRC-16-CCITT of the active
// pixels instead of their modular sum.
module vga_2bit_rx
   import vga_2bit_pkg::*;
#(
   parameter int HW              = 12,
   parameter int VW              = 11,
   parameter int SUM_W           = 24,
   parameter int SYNC_ACTIVE_LOW = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hs,
   input  logic             vs,
   input  logic             blank,
   input  logic [1:0]       r,
   input  logic [1:0]       g,
   input  logic [1:0]       b,
   output logic [HW-1:0]    h_total,
   output logic [HW-1:0]    h_active,
   output logic [VW-1:0]    v_total,
   output logic [VW-1:0]    v_active,
   output logic [SUM_W-1:0] frame_sum,
   output logic             frame_valid,
   output logic             locked,
   output logic             timing_err
);

   localparam logic [HW-1:0] H_MAX = '1;
   localparam logic [VW-1:0] V_MAX = '1;

   logic hs_start, vs_start;

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_hs (
      .clk   (clk),
      .reset (reset),
      .sync  (hs),
      .start (hs_start)
   );

   vga_sync_edge #(.ACTIVE_LOW(SYNC_ACTIVE_LOW != 0)) u_vs (
      .clk   (clk),
      .reset (reset),
      .sync  (vs),
      .start (vs_start)
   );

   logic       active;
   logic [5:0] pix;

   assign active = ~blank;
   assign pix    = {r, g, b};

   logic [HW-1:0] h_cnt, a_cnt, h_act_last, last_len, first_len;
   logic          h_seen, first_ok, line_bad, frame_bad;
   logic [VW-1:0] v_cnt, v_act;
   logic [HW-1:0] ref_h;
   logic [VW-1:0] ref_v;

   // A line completes only at an hs start that has a previous hs start.
   logic [HW-1:0] cur_len;
   logic          len_ev, h_sat, v_sat, first_act;

   assign cur_len   = h_cnt + 1'b1;
   assign len_ev    = hs_start & h_seen;
   assign h_sat     = (h_cnt == H_MAX) & ~hs_start;
   assign v_sat     = hs_start & ~vs_start & (v_cnt == V_MAX);
   assign first_act = active & (hs_start | (a_cnt == '0));

   // Frame-end view: the line closed by a coinciding hs start still belongs
   // to the frame that is ending.
   logic [HW-1:0] fin_h_total, fin_h_act;
   logic          fin_line_bad, fin_bad, good;

   assign fin_h_total  = len_ev ? cur_len : last_len;
   assign fin_h_act    = (a_cnt != '0) ? a_cnt : h_act_last;
   assign fin_line_bad = line_bad |
                         (len_ev & first_ok & (cur_len != first_len));
   assign fin_bad      = frame_bad | h_sat;
   assign good         = (fin_h_total == ref_h) && (v_cnt == ref_v) &&
                         !fin_bad && !fin_line_bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt      <= '0;
         h_seen     <= 1'b0;
         a_cnt      <= '0;
         h_act_last <= '0;
         last_len   <= '0;
         first_len  <= '0;
         first_ok   <= 1'b0;
         line_bad   <= 1'b0;
         frame_bad  <= 1'b0;
         v_cnt      <= '0;
         v_act      <= '0;
      end else begin
         if (hs_start) begin
            h_cnt  <= '0;
            h_seen <= 1'b1;
            a_cnt  <= {{(HW-1){1'b0}}, active};
            if (len_ev)
               last_len <= cur_len;
         end else begin
            if (h_cnt != H_MAX)
               h_cnt <= h_cnt + 1'b1;
            if (active && a_cnt != H_MAX)
               a_cnt <= a_cnt + 1'b1;
         end

         if (vs_start) begin
            h_act_last <= '0;
            first_ok   <= 1'b0;
            line_bad   <= 1'b0;
            frame_bad  <= 1'b0;
            v_cnt      <= {{(VW-1){1'b0}}, hs_start};
            v_act      <= {{(VW-1){1'b0}}, first_act};
         end else begin
            if (hs_start && a_cnt != '0)
               h_act_last <= a_cnt;
            if (len_ev) begin
               if (!first_ok) begin
                  first_len <= cur_len;
                  first_ok  <= 1'b1;
               end else if (cur_len != first_len) begin
                  line_bad <= 1'b1;
               end
            end
            if (h_sat || v_sat)
               frame_bad <= 1'b1;
            if (hs_start && v_cnt != V_MAX)
               v_cnt <= v_cnt + 1'b1;
            if (first_act && v_act != V_MAX)
               v_act <= v_act + 1'b1;
         end
      end
   end

   logic [SUM_W-1:0] sum_now;

`ifdef VGA_RX_CRC_EN
   logic [15:0] crc, crc_base;

   assign crc_base = vs_start ? CRC_INIT : crc;

   always_ff @(posedge clk) begin
      if (reset)
         crc <= CRC_INIT;
      else if (active)
         crc <= crc16_step6(crc_base, pix);
      else
         crc <= crc_base;
   end

   assign sum_now = {{(SUM_W-16){1'b0}}, crc};
`else
   logic [SUM_W-1:0] acc, acc_base;

   assign acc_base = vs_start ? '0 : acc;

   always_ff @(posedge clk) begin
      if (reset)
         acc <= '0;
      else if (active)
         acc <= acc_base + {{(SUM_W-6){1'b0}}, pix};
      else
         acc <= acc_base;
   end

   assign sum_now = acc;
`endif

   rx_state_t state, state_nxt;
   logic      publish, err, ref_ld;

   always_ff @(posedge clk) begin
      if (reset)
         state <= SEARCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      err       = 1'b0;
      ref_ld    = 1'b0;
      if (vs_start) begin
         case (state)
            SEARCH: state_nxt = FIRST;
            FIRST: begin
               publish   = 1'b1;
               ref_ld    = 1'b1;
               state_nxt = CHECK;
            end
            CHECK: begin
               publish = 1'b1;
               if (good) begin
                  state_nxt = LOCKED;
               end else begin
                  err    = 1'b1;
                  ref_ld = 1'b1;
               end
            end
            LOCKED: begin
               publish = 1'b1;
               if (!good) begin
                  err       = 1'b1;
                  ref_ld    = 1'b1;
                  state_nxt = CHECK;
               end
            end
            default: state_nxt = SEARCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         h_total     <= '0;
         h_active    <= '0;
         v_total     <= '0;
         v_active    <= '0;
         frame_sum   <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         timing_err  <= 1'b0;
         ref_h       <= '0;
         ref_v       <= '0;
      end else begin
         frame_valid <= publish;
         timing_err  <= err;
         locked      <= (state_nxt == LOCKED);
         if (publish) begin
            h_total   <= fin_h_total;
            h_active  <= fin_h_act;
            v_total   <= v_cnt;
            v_active  <= v_act;
            frame_sum <= sum_now;
         end
         if (ref_ld) begin
            ref_h <= fin_h_total;
            ref_v <= v_cnt;
         end
      end
   end

endmodule

// File: tb/tb_vga_2bit_rx.sv
// Self-checking bench for vga_2bit_rx.
// Frames are generated here; expected per-frame results go to a scoreboard.
module tb_vga_2bit_rx;
   import vga_2bit_pkg::*;

   localparam int HW    = 12;
   localparam int VW    = 11;
   localparam int SUM_W = 24;

   logic             clk = 1'b0;
   logic             reset;
   logic             hs, vs, blank;
   logic [1:0]       r, g, b;
   logic [HW-1:0]    h_total, h_active;
   logic [VW-1:0]    v_total, v_active;
   logic [SUM_W-1:0] frame_sum;
   logic             frame_valid, locked, timing_err;

   typedef struct packed {
      logic [HW-1:0]    ht;
      logic [HW-1:0]    ha;
      logic [VW-1:0]    vt;
      logic [VW-1:0]    va;
      logic [SUM_W-1:0] sum;
      logic             lck;
      logic             err;
   } exp_t;

   exp_t sb[$];
   int   n_run   = 0;
   int   n_fail  = 0;
   int   n_valid = 0;
   int   n_frame = 0;
   exp_t mon_e, mon_got;
   logic mon_prev = 1'b0;

   always #5 clk = ~clk;

   vga_2bit_rx #(
      .HW(HW), .VW(VW), .SUM_W(SUM_W), .SYNC_ACTIVE_LOW(1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .hs          (hs),
      .vs          (vs),
      .blank       (blank),
      .r           (r),
      .g           (g),
      .b           (b),
      .h_total     (h_total),
      .h_active    (h_active),
      .v_total     (v_total),
      .v_active    (v_active),
      .frame_sum   (frame_sum),
      .frame_valid (frame_valid),
      .locked      (locked),
      .timing_err  (timing_err)
   );

   // Scoreboard monitor: every frame_valid pops one expected frame.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         mon_got = {h_total, h_active, v_total, v_active,
                    frame_sum, locked, timing_err};
         if (frame_valid) begin
            n_valid++;
            n_run++;
            if (mon_prev) begin
               n_fail++;
               $display("FAIL valid_width: frame_valid high 2+ clks, expected 1");
            end
            n_run++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_valid: frame_valid=1 ht=%0d vt=%0d, expected none",
                        h_total, v_total);
            end else begin
               mon_e = sb.pop_front();
               n_frame++;
               if (mon_got !== mon_e) begin
                  n_fail++;
                  $display("FAIL frame%0d: got ht=%0d ha=%0d vt=%0d va=%0d sum=%0h lck=%0b err=%0b, expected ht=%0d ha=%0d vt=%0d va=%0d sum=%0h lck=%0b err=%0b",
                           n_frame, mon_got.ht, mon_got.ha, mon_got.vt, mon_got.va,
                           mon_got.sum, mon_got.lck, mon_got.err,
                           mon_e.ht, mon_e.ha, mon_e.vt, mon_e.va,
                           mon_e.sum, mon_e.lck, mon_e.err);
               end
            end
         end
         if (timing_err && !frame_valid) begin
            n_run++;
            n_fail++;
            $display("FAIL err_align: timing_err=1 with frame_valid=0, expected both");
         end
         mon_prev = frame_valid;
      end
   end

   task automatic idle_inputs();
      hs    = 1'b1;
      vs    = 1'b1;
      blank = 1'b1;
      {r, g, b} = 6'h00;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Drives nlines lines of a frame; a full frame pushes its expected result.
   // Line s_line is lengthened by s_by clocks (s_line < 0: none).
   task automatic drive_frame(
      input int h, input int ha, input int v, input int va,
      input int hsw, input int vsw,
      input logic [5:0] col, input bit pat,
      input int s_line, input int s_by, input int nlines,
      input bit lck, input bit err
   );
      exp_t             e;
      logic [5:0]       p;
      bit               act;
      int               len, ho, vo;
      logic [15:0]      crc;
      logic [SUM_W-1:0] sum;
      ho  = hsw + 2;
      vo  = vsw + 1;
      crc = CRC_INIT;
      sum = '0;
      for (int y = 0; y < nlines; y++) begin
         len = h + ((y == s_line) ? s_by : 0);
         for (int x = 0; x < len; x++) begin
            @(negedge clk);
            act = (x >= ho) && (x < ho + ha) && (y >= vo) && (y < vo + va);
            p = pat ? 6'(x * 5 + y * 3) : col;
            hs = (x < hsw) ? 1'b0 : 1'b1;
            vs = (y < vsw) ? 1'b0 : 1'b1;
            blank = !act;
            {r, g, b} = p;
            if (act) begin
               crc = crc16_step6(crc, p);
               sum = sum + SUM_W'(p);
            end
         end
      end
      if (nlines == v) begin
         e.ht = HW'(h + ((s_line == v - 1) ? s_by : 0));
         e.ha = HW'(ha);
         e.vt = VW'(v);
         e.va = VW'(va);
`ifdef VGA_RX_CRC_EN
         e.sum = SUM_W'(crc);
`else
         e.sum = sum;
`endif
         e.lck = lck;
         e.err = err;
         sb.push_back(e);
      end
   endtask

   // Opens one more frame so the last driven frame gets published.
   task automatic tail();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         hs    = 1'b0;
         vs    = 1'b0;
         blank = 1'b1;
      end
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      n_run++;
      if ({h_total, h_active, v_total, v_active, frame_sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_meas: got ht=%0d ha=%0d vt=%0d va=%0d sum=%0h, expected 0",
                  h_total, h_active, v_total, v_active, frame_sum);
      end
      n_run++;
      if ({frame_valid, locked, timing_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b, expected 000",
                  {frame_valid, locked, timing_err});
      end
      n_run++;
      if (dut.state !== SEARCH) begin
         n_fail++;
         $display("FAIL reset_state: got %0d, expected %0d", dut.state, SEARCH);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tiny();
      int v0;
      do_reset();
      v0 = n_valid;
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b0, 1'b0);
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b1, 1'b0);
      n_run++;
      if (dut.state !== CHECK) begin
         n_fail++;
         $display("FAIL tiny_state: got %0d, expected %0d", dut.state, CHECK);
      end
      n_run++;
      if (n_valid != v0 + 1) begin
         n_fail++;
         $display("FAIL tiny_count: got %0d pulses, expected %0d", n_valid - v0, 1);
      end
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b1, 1'b0);
      n_run++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL tiny_lock: got locked=%b, expected 1", locked);
      end
   endtask

   task automatic test_stretch();
      int v0;
      v0 = n_valid;
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, 4, 1, 10, 1'b0, 1'b1);
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b1, 1'b0);
      tail();
      n_run++;
      if (n_valid != v0 + 3) begin
         n_fail++;
         $display("FAIL stretch_count: got %0d pulses, expected %0d", n_valid - v0, 3);
      end
   endtask

   task automatic test_wide();
      do_reset();
      drive_frame(800, 640, 12, 8, 96, 1, 6'h00, 1'b1, -1, 0, 12, 1'b0, 1'b0);
      drive_frame(800, 640, 12, 8, 96, 1, 6'h00, 1'b1, -1, 0, 12, 1'b1, 1'b0);
      drive_frame(800, 640, 12, 8, 96, 1, 6'h00, 1'b1, -1, 0, 12, 1'b1, 1'b0);
      tail();
      n_run++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL wide_lock: got locked=%b, expected 1", locked);
      end
   endtask

   task automatic test_saturate();
      do_reset();
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b0, 1'b0);
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, 8, 4980, 10, 1'b0, 1'b1);
      tail();
      n_run++;
      if (locked !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_nolock: got locked=%b, expected 0", locked);
      end
   endtask

   task automatic test_reset_mid();
      int v0;
      do_reset();
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b0, 1'b0);
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b1, 1'b0);
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 5, 1'b0, 1'b0);
      n_run++;
      if (locked !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_prelock: got locked=%b, expected 1", locked);
      end
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      @(posedge clk);
      #1;
      n_run++;
      if ({h_total, h_active, v_total, v_active, frame_sum,
           frame_valid, locked, timing_err} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got ht=%0d vt=%0d sum=%0h lck=%b, expected all 0",
                  h_total, v_total, frame_sum, locked);
      end
      @(negedge clk);
      reset = 1'b0;
      v0 = n_valid;
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b0, 1'b0);
      n_run++;
      if (n_valid != v0) begin
         n_fail++;
         $display("FAIL mid_novalid: got %0d pulses, expected 0", n_valid - v0);
      end
      drive_frame(20, 12, 10, 6, 2, 1, 6'h30, 1'b0, -1, 0, 10, 1'b1, 1'b0);
      tail();
      n_run++;
      if (n_valid != v0 + 2) begin
         n_fail++;
         $display("FAIL mid_count: got %0d pulses, expected %0d", n_valid - v0, 2);
      end
   endtask

   task automatic test_single_pixel();
      do_reset();
      drive_frame(20, 1, 10, 1, 2, 1, 6'h3F, 1'b0, -1, 0, 10, 1'b0, 1'b0);
      drive_frame(20, 1, 10, 1, 2, 1, 6'h3F, 1'b0, -1, 0, 10, 1'b1, 1'b0);
      tail();
   endtask

   initial begin
      test_reset();
      test_tiny();
      test_stretch();
      test_wide();
      test_saturate();
      test_reset_mid();
      test_single_pixel();
      repeat (4) @(negedge clk);
      n_run++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d frames unpublished, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
